// File: rtl/midi_note_parser.sv
// MIDI byte-stream decoder: Note On/Off with running status on one channel (or omni).
// Produces a registered monophonic, last-note-priority note index, velocity and gate.
module midi_note_parser #(
  parameter int unsigned MIDI_CHANNEL = 0,
  parameter bit          OMNI         = 1'b0
) (
  input  logic       inCLK,
  input  logic       inRST_N,
  input  logic [7:0] inByte,
  input  logic       inByteValid,
  output logic [6:0] outMidiFrequencyIndex,
  output logic [6:0] outVelocity,
  output logic       outGate,
  output logic       outNoteEvent
);

  localparam logic [3:0] Channel = MIDI_CHANNEL[3:0];

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_e;

  // Reset asserts asynchronously, releases two clock edges after inRST_N rises.
  logic rst_meta_q, rst_sync_q;
  logic rst_n;

  always_ff @(posedge inCLK or negedge inRST_N) begin
    if (!inRST_N) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] index_q, index_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       event_q, event_d;

  logic       is_realtime, is_system, is_channel;
  logic       one_byte_msg, chan_match;
  logic       is_note_on_status, is_note_off_status;
  logic       msg_done;
  logic [6:0] msg_d1, msg_d2;

  always_comb begin
    is_realtime        = (inByte[7:3] == 5'b11111);
    is_system          = (inByte[7:3] == 5'b11110);
    is_channel         = inByte[7] && (inByte[7:4] != 4'hF);
    one_byte_msg       = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
    chan_match         = OMNI || (status_q[3:0] == Channel);
    is_note_on_status  = (status_q[7:4] == 4'h9);
    is_note_off_status = (status_q[7:4] == 4'h8);
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    index_d  = index_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    msg_done = 1'b0;
    msg_d1   = d1_q;
    msg_d2   = 7'd0;

    if (inByteValid) begin
      if (is_realtime) begin
        // Real-time bytes are transparent, even mid-message.
      end else if (is_system) begin
        state_d  = StIdle;
        status_d = 8'h00;
      end else if (is_channel) begin
        state_d  = StWaitD1;
        status_d = inByte;
      end else begin
        case (state_q)
          StIdle: ;
          StWaitD1: begin
            d1_d = inByte[6:0];
            if (one_byte_msg) begin
              msg_done = 1'b1;
              msg_d1   = inByte[6:0];
            end else begin
              state_d = StWaitD2;
            end
          end
          StWaitD2: begin
            msg_done = 1'b1;
            msg_d2   = inByte[6:0];
            state_d  = StWaitD1;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    if (msg_done && chan_match) begin
      if (is_note_on_status && (msg_d2 != 7'd0)) begin
        index_d = msg_d1;
        vel_d   = msg_d2;
        gate_d  = 1'b1;
      end else if ((is_note_on_status || is_note_off_status) && gate_q &&
                   (msg_d1 == index_q)) begin
        // Only releasing the held note closes the gate; stale releases are ignored.
        gate_d = 1'b0;
      end
    end

    event_d = (gate_d != gate_q) || (index_d != index_q);
  end

  always_ff @(posedge inCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      index_q  <= 7'd0;
      vel_q    <= 7'd0;
      gate_q   <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      index_q  <= index_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      event_q  <= event_d;
    end
  end

  assign outMidiFrequencyIndex = index_q;
  assign outVelocity           = vel_q;
  assign outGate               = gate_q;
  assign outNoteEvent          = event_q;

endmodule
